// File: rtl/pipeline_defs.sv
// Shared definitions for the pipeline hazard controller: forward-select codes,
// HI/LO busy-timer states and register-number width.
package pipeline_defs;

   localparam int unsigned REG_W      = 5;
   localparam int unsigned HILO_CNT_W = 4;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_EX  = 2'b01,
      FWD_MEM = 2'b10,
      FWD_WB  = 2'b11
   } fwd_sel_e;

   typedef enum logic {
      RUN       = 1'b0,
      HILO_WAIT = 1'b1
   } hilo_state_e;

   // A stage supplies a source only if it writes a nonzero register equal to it.
   function automatic logic rd_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] rd,
                                     input logic             rf_enable);
      return rf_enable && (rd == src) && (rd != '0);
   endfunction

endpackage

// File: rtl/hilo_busy_timer.sv
// HI/LO unit busy timer: holds hilo_busy for MULT_LAT cycles after a mult/div
// leaves EX; a new start while waiting reloads the count.
module hilo_busy_timer
   import pipeline_defs::*;
#(
   parameter int unsigned MULT_LAT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ex_hilo_start,
   output logic hilo_busy
);

   localparam logic [HILO_CNT_W-1:0] LAT = HILO_CNT_W'(MULT_LAT);

   hilo_state_e           state, state_nxt;
   logic [HILO_CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (ex_hilo_start) begin
         cnt_nxt   = LAT;
         state_nxt = HILO_WAIT;
      end else begin
         case (state)
            RUN: begin
               cnt_nxt = '0;
            end
            HILO_WAIT: begin
               cnt_nxt = cnt - 1'b1;
               if (cnt == HILO_CNT_W'(1)) state_nxt = RUN;
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = RUN;
            end
         endcase
      end
   end

   assign hilo_busy = (state == HILO_WAIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: forwarding selects,
// load-use and HI/LO stalls. Optional stall statistics under HAZARD_STATS_EN.
module pipeline_hazard_ctrl
   import pipeline_defs::*;
#(
   parameter int unsigned MULT_LAT = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_hilo_rd,
   input  logic             id_hilo_op,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_rf_enable,
   input  logic             ex_load_instr,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_rf_enable,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             wb_rf_enable,
   input  logic             ex_hilo_start,
   output logic             le_pc,
   output logic             le_npc,
   output logic             le_ifid,
   output logic             nop_idex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             hilo_busy
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] hilo_stall_cnt
`endif
);

   logic     rs_ex, rs_mem, rs_wb;
   logic     rt_ex, rt_mem, rt_wb;
   logic     lu, hs, stall;
   fwd_sel_e sel_a, sel_b;

   hilo_busy_timer #(
      .MULT_LAT (MULT_LAT)
   ) u_hilo_busy_timer (
      .clk           (clk),
      .reset         (reset),
      .ex_hilo_start (ex_hilo_start),
      .hilo_busy     (hilo_busy)
   );

   assign rs_ex  = id_use_rs && rd_match(id_rs, ex_rd,  ex_rf_enable);
   assign rs_mem = id_use_rs && rd_match(id_rs, mem_rd, mem_rf_enable);
   assign rs_wb  = id_use_rs && rd_match(id_rs, wb_rd,  wb_rf_enable);
   assign rt_ex  = id_use_rt && rd_match(id_rt, ex_rd,  ex_rf_enable);
   assign rt_mem = id_use_rt && rd_match(id_rt, mem_rd, mem_rf_enable);
   assign rt_wb  = id_use_rt && rd_match(id_rt, wb_rd,  wb_rf_enable);

   assign lu    = id_valid && ex_load_instr && (rs_ex || rt_ex);
   assign hs    = id_valid && (id_hilo_rd || id_hilo_op) && (hilo_busy || ex_hilo_start);
   assign stall = lu || hs;

   // Youngest producer wins; selects are parked at the register file while stalled.
   always_comb begin
      sel_a = FWD_RF;
      sel_b = FWD_RF;
      if (!stall) begin
         if (rs_ex)       sel_a = FWD_EX;
         else if (rs_mem) sel_a = FWD_MEM;
         else if (rs_wb)  sel_a = FWD_WB;
         if (rt_ex)       sel_b = FWD_EX;
         else if (rt_mem) sel_b = FWD_MEM;
         else if (rt_wb)  sel_b = FWD_WB;
      end
   end

   assign fwd_a    = sel_a;
   assign fwd_b    = sel_b;
   assign le_pc    = !stall;
   assign le_npc   = !stall;
   assign le_ifid  = !stall;
   assign nop_idex = stall;

`ifdef HAZARD_STATS_EN
   // A cycle with both stall causes is booked as load-use only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lu_stall_cnt   <= '0;
         hilo_stall_cnt <= '0;
      end else begin
         if (lu && (lu_stall_cnt != '1))
            lu_stall_cnt <= lu_stall_cnt + 1'b1;
         if (hs && !lu && (hilo_stall_cnt != '1))
            hilo_stall_cnt <= hilo_stall_cnt + 1'b1;
      end
   end
`endif

endmodule
